// File: rtl/counter_bcd_min_sec.sv
// Seconds/minutes stage of the BCD clock: 1 Hz prescaler, MM:SS BCD counter,
// rollover carry to the hour stage, manual set while stopped, 7-segment decode.

module seven_segment (
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);
   // Active-high segments, bit order {g,f,e,d,c,b,a}
   always_comb begin
      case (i_bcd)
         4'd0:    o_seg = 7'h3F;
         4'd1:    o_seg = 7'h06;
         4'd2:    o_seg = 7'h5B;
         4'd3:    o_seg = 7'h4F;
         4'd4:    o_seg = 7'h66;
         4'd5:    o_seg = 7'h6D;
         4'd6:    o_seg = 7'h7D;
         4'd7:    o_seg = 7'h07;
         4'd8:    o_seg = 7'h7F;
         4'd9:    o_seg = 7'h6F;
         default: o_seg = 7'h00;
      endcase
   end
endmodule

module counter_bcd_min_sec #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        clr,
   input  logic        inc_sec,
   input  logic        inc_min,
   output logic        tick,
   output logic        carry_out,
   output logic [15:0] s,
   output logic [27:0] q
);
   localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_TOP = PW'(TICK_DIV - 1);

   // One BCD step of a 00..59 field
   function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) r = 8'h00;
         else                r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   logic [PW-1:0] r_presc;
   logic [15:0]   r_s;
   logic          r_inc_sec_d;
   logic          r_inc_min_d;
   logic [PW-1:0] w_presc_next;
   logic [15:0]   w_s_next;
   logic          w_sec_edge;
   logic          w_min_edge;
   logic          w_tick;
   logic          w_carry;

   // Next-state: clr beats counting, counting beats set buttons
   always_comb begin
      w_sec_edge   = inc_sec & ~r_inc_sec_d;
      w_min_edge   = inc_min & ~r_inc_min_d;
      w_tick       = run & (r_presc == PRESC_TOP) & ~clr;
      w_carry      = w_tick & (r_s == 16'h5959);
      w_presc_next = r_presc;
      w_s_next     = r_s;
      if (clr) begin
         w_presc_next = {PW{1'b0}};
         w_s_next     = 16'h0000;
      end else if (run) begin
         if (r_presc == PRESC_TOP) w_presc_next = {PW{1'b0}};
         else                      w_presc_next = r_presc + PW'(1);
         if (w_tick) begin
            w_s_next[7:0] = bcd60_inc(r_s[7:0]);
            if (r_s[7:0] == 8'h59) w_s_next[15:8] = bcd60_inc(r_s[15:8]);
            else                   w_s_next[15:8] = r_s[15:8];
         end else begin
            w_s_next = r_s;
         end
      end else begin
         // Held at zero while stopped so a resume yields a full first second
         w_presc_next = {PW{1'b0}};
         if (w_sec_edge) w_s_next[7:0] = bcd60_inc(r_s[7:0]);
         else            w_s_next[7:0] = r_s[7:0];
         if (w_min_edge) w_s_next[15:8] = bcd60_inc(r_s[15:8]);
         else            w_s_next[15:8] = r_s[15:8];
      end
   end

   // State registers; button samples update every cycle regardless of mode
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc     <= {PW{1'b0}};
         r_s         <= 16'h0000;
         r_inc_sec_d <= 1'b0;
         r_inc_min_d <= 1'b0;
      end else begin
         r_presc     <= w_presc_next;
         r_s         <= w_s_next;
         r_inc_sec_d <= inc_sec;
         r_inc_min_d <= inc_min;
      end
   end

   assign tick      = w_tick;
   assign carry_out = w_carry;
   assign s         = r_s;

   seven_segment u_seg0 (.i_bcd(r_s[3:0]),   .o_seg(q[6:0]));
   seven_segment u_seg1 (.i_bcd(r_s[7:4]),   .o_seg(q[13:7]));
   seven_segment u_seg2 (.i_bcd(r_s[11:8]),  .o_seg(q[20:14]));
   seven_segment u_seg3 (.i_bcd(r_s[15:12]), .o_seg(q[27:21]));
endmodule
